// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
// Avalon-MM slave that drives six active-low 7-segment digits (HEX0..HEX5).
// It holds a 24-bit hex value, a raw-segment mode, per-digit decimal points,
// per-digit blink and an optional rotating scroll.
//
// Configuration macro: HEX_DISPLAY_SCROLL_EN
//   defined   -> scroll FSM, scroll counter and position logic are built.
//   undefined -> no scroll hardware. pos is tied to 0. CTRL[3] is stored but
//                reads 0 and has no effect. STATUS[3:1] reads 0.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[2:0]        word register index
//   chipselect          slave select
//   write_n, read_n     active-low strobes (read data is valid regardless)
//   writedata[31:0]     write data
//   readdata[31:0]      combinational read data, zero wait states
//   hex0..hex5[7:0]     active-low segments, bit0=a .. bit6=g, bit7=DP
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCROLL_DIV = 12500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam int BW = $clog2(BLINK_DIV);

  logic [3:0]    ctrl_reg;
  logic [23:0]   value_reg;
  logic [5:0]    dp_reg;
  logic [5:0]    blink_mask_reg;
  logic [47:0]   raw_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_reg;
  logic [2:0]    pos_reg;
  logic [3:0]    ctrl_eff;
  logic [3:0]    ctrl_rd;
  logic          wr_en;
  logic          blink_run;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  assign wr_en = chipselect && !write_n;

  // Control value as it will be after this edge. Counters stop when either the
  // current or the incoming control says "off", so a disabling CTRL write on a
  // terminal-count edge suppresses the toggle/increment and clears the counter.
  assign ctrl_eff = (wr_en && address == 3'd0) ? writedata[3:0] : ctrl_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg       <= 4'h3;
      value_reg      <= '0;
      dp_reg         <= '0;
      blink_mask_reg <= '0;
      raw_reg        <= '1;
    end else if (wr_en) begin
      case (address)
        3'd0:    ctrl_reg        <= writedata[3:0];
        3'd1:    value_reg       <= writedata[23:0];
        3'd2:    dp_reg          <= writedata[5:0];
        3'd3:    blink_mask_reg  <= writedata[5:0];
        3'd4:    raw_reg[31:0]   <= writedata;
        3'd5:    raw_reg[47:32]  <= writedata[15:0];
        default: ;
      endcase
    end
  end

  // Blink phase generator.
  assign blink_run = ctrl_reg[0] && ctrl_reg[2] && ctrl_eff[0] && ctrl_eff[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (!blink_run) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

`ifdef HEX_DISPLAY_SCROLL_EN
  localparam int SW = $clog2(SCROLL_DIV);

  typedef enum logic {S_IDLE, S_RUN} scroll_state_t;

  scroll_state_t state_reg, state_next;
  logic [SW-1:0] scroll_cnt_reg, scroll_cnt_next;
  logic [2:0]    pos_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      scroll_cnt_reg <= '0;
      pos_reg        <= 3'd0;
    end else begin
      state_reg      <= state_next;
      scroll_cnt_reg <= scroll_cnt_next;
      pos_reg        <= pos_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    scroll_cnt_next = scroll_cnt_reg;
    pos_next        = pos_reg;
    case (state_reg)
      S_IDLE: begin
        scroll_cnt_next = '0;
        pos_next        = 3'd0;
        if (ctrl_reg[0] && ctrl_reg[3]) state_next = S_RUN;
      end
      S_RUN: begin
        if (!(ctrl_eff[0] && ctrl_eff[3])) begin
          state_next      = S_IDLE;
          scroll_cnt_next = '0;
          pos_next        = 3'd0;
        end else if (scroll_cnt_reg == SW'(SCROLL_DIV - 1)) begin
          scroll_cnt_next = '0;
          pos_next        = (pos_reg == 3'd5) ? 3'd0 : pos_reg + 3'd1;
        end else begin
          scroll_cnt_next = scroll_cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ctrl_rd = ctrl_reg;

  logic unused_sigs;
  assign unused_sigs = read_n;
`else
  assign pos_reg = 3'd0;
  assign ctrl_rd = {1'b0, ctrl_reg[2:0]};

  logic unused_sigs;
  assign unused_sigs = read_n ^ ctrl_reg[3] ^ ctrl_eff[3];
`endif

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = {28'd0, ctrl_rd};
      3'd1:    readdata = {8'd0, value_reg};
      3'd2:    readdata = {26'd0, dp_reg};
      3'd3:    readdata = {26'd0, blink_mask_reg};
      3'd4:    readdata = raw_reg[31:0];
      3'd5:    readdata = {16'd0, raw_reg[47:32]};
      3'd6:    readdata = {28'd0, pos_reg, phase_reg};
      default: readdata = '0;
    endcase
  end

  // Per-digit output pipeline: rotate source, select decode/raw, apply DP,
  // then blanking by blink and by global enable. Outputs are registered.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] src_sum;
      logic [2:0] src;
      logic [7:0] pattern_next;
      logic [7:0] out_reg;

      assign src_sum = 4'(gi) + {1'b0, pos_reg};
      assign src     = (src_sum >= 4'd6) ? 3'(src_sum - 4'd6) : src_sum[2:0];

      always_comb begin
        pattern_next = ctrl_reg[1] ? seg_decode(value_reg[{src, 2'b00} +: 4])
                                   : raw_reg[{src, 3'b000} +: 8];
        if (dp_reg[gi]) pattern_next[7] = 1'b0;
        if (ctrl_reg[2] && blink_mask_reg[gi] && phase_reg) pattern_next = 8'hFF;
        if (!ctrl_reg[0]) pattern_next = 8'hFF;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_reg <= 8'hFF;
        else          out_reg <= pattern_next;
      end
    end
  endgenerate

  assign hex0 = g_digit[0].out_reg;
  assign hex1 = g_digit[1].out_reg;
  assign hex2 = g_digit[2].out_reg;
  assign hex3 = g_digit[3].out_reg;
  assign hex4 = g_digit[4].out_reg;
  assign hex5 = g_digit[5].out_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Testbench for hex_display_ctrl. A behavioural model tracks register
// contents and the number of cycles the blink/scroll timers have been
// running; phase and pos are derived arithmetically from those counts.
// A compare process checks all six digits against the model on every
// falling edge; directed sections add hand-computed literal checks and a
// randomized section exercises the register map.
module tb_hex_display_ctrl;
  localparam int BDIV = 4;
  localparam int SDIV = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0]  hx [6];

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(BDIV), .SCROLL_DIV(SDIV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  int total = 0;
  int bad = 0;

  // ---------------- behavioural model ----------------
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0]  m_ctrl;
  logic [23:0] m_value;
  logic [5:0]  m_dp, m_mask;
  logic [47:0] m_raw;
  int          m_blink_cycles;   // consecutive edges the blink timer has run
  int          m_scroll_cycles;  // edges counted while scrolling
  bit          m_run;
  logic [7:0]  m_exp [6];

  function automatic bit blink_on(input logic [3:0] c);
    return c[0] && c[2];
  endfunction

  function automatic bit scroll_on(input logic [3:0] c);
`ifdef HEX_DISPLAY_SCROLL_EN
    return c[0] && c[3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_phase();
    return (m_blink_cycles / BDIV) % 2;
  endfunction

  function automatic int m_pos();
    return m_run ? (m_scroll_cycles / SDIV) % 6 : 0;
  endfunction

  function automatic logic [7:0] digit_pattern(input int i);
    int s;
    logic [7:0] p;
    s = (i + m_pos()) % 6;
    if (m_ctrl[1]) p = seg_tab[4'((m_value >> (4 * s)) & 24'hF)];
    else           p = 8'((m_raw >> (8 * s)) & 48'hFF);
    if (m_dp[i]) p = p & 8'h7F;
    if (m_ctrl[2] && m_mask[i] && m_phase() == 1) p = 8'hFF;
    if (!m_ctrl[0]) p = 8'hFF;
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
`ifdef HEX_DISPLAY_SCROLL_EN
      3'd0: return {28'd0, m_ctrl};
`else
      3'd0: return {28'd0, 1'b0, m_ctrl[2:0]};
`endif
      3'd1: return {8'd0, m_value};
      3'd2: return {26'd0, m_dp};
      3'd3: return {26'd0, m_mask};
      3'd4: return m_raw[31:0];
      3'd5: return {16'd0, m_raw[47:32]};
      3'd6: return 32'((m_pos() << 1) | m_phase());
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 4'h3; m_value = '0; m_dp = '0; m_mask = '0; m_raw = '1;
    m_blink_cycles = 0; m_scroll_cycles = 0; m_run = 1'b0;
    for (int i = 0; i < 6; i++) m_exp[i] = 8'hFF;
  endtask

  task automatic model_step();
    logic [3:0] new_ctrl;
    bit wr;
    wr = chipselect && !write_n;
    new_ctrl = (wr && address == 3'd0) ? writedata[3:0] : m_ctrl;
    for (int i = 0; i < 6; i++) m_exp[i] = digit_pattern(i);
    if (blink_on(m_ctrl) && blink_on(new_ctrl)) m_blink_cycles++;
    else m_blink_cycles = 0;
    if (!m_run) begin
      m_scroll_cycles = 0;
      m_run = scroll_on(m_ctrl);
    end else if (scroll_on(new_ctrl)) begin
      m_scroll_cycles++;
    end else begin
      m_run = 1'b0;
      m_scroll_cycles = 0;
    end
    if (wr) begin
      case (address)
        3'd0: m_ctrl = writedata[3:0];
        3'd1: m_value = writedata[23:0];
        3'd2: m_dp = writedata[5:0];
        3'd3: m_mask = writedata[5:0];
        3'd4: m_raw[31:0] = writedata;
        3'd5: m_raw[47:32] = writedata[15:0];
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) check($sformatf("hex%0d", i), {24'd0, hx[i]}, {24'd0, m_exp[i]});
    end
  end

  // ---------------- bus helpers (entered just after a falling edge) ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1;
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
    $display("rd addr=%0d data=%h", a, d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int n, blanks;

    // Reset and release
    tick(3);
    check("rst_hex0", {24'd0, hex0}, 32'hFF);
    check("rst_hex5", {24'd0, hex5}, 32'hFF);
    reset_n = 1'b1;
    tick(1);
    check("first_hex0", {24'd0, hex0}, 32'hC0);
    check("first_hex5", {24'd0, hex5}, 32'hC0);
    bus_read(3'd0, rd); check("ctrl_rst", rd, 32'h3);
    bus_read(3'd4, rd); check("rawlo_rst", rd, 32'hFFFF_FFFF);

    // Hex decode with a decimal point
    bus_write(3'd1, 32'h0000_A5E9);
    bus_write(3'd2, 32'h1);
    tick(1);
    check("dec_hex0", {24'd0, hex0}, 32'h10);
    check("dec_hex1", {24'd0, hex1}, 32'h86);
    check("dec_hex2", {24'd0, hex2}, 32'h92);
    check("dec_hex3", {24'd0, hex3}, 32'h88);
    check("dec_hex4", {24'd0, hex4}, 32'hC0);
    check("dec_hex5", {24'd0, hex5}, 32'hC0);

    // Blink on digit 1
    bus_write(3'd3, 32'h2);
    bus_write(3'd0, 32'h7);
    tick(2);
    blanks = 0;
    for (int k = 0; k < 4 * BDIV; k++) begin
      if (hex1 == 8'hFF) blanks++;
      tick(1);
    end
    check("blink_duty", blanks, 2 * BDIV);
    n = 0;
    while (!(m_phase() == 1 && (m_blink_cycles % BDIV) == BDIV - 1) && n < 40) begin
      tick(1); n++;
    end
    check("wait_blink_tc", (n < 40) ? 1 : 0, 1);
    bus_write(3'd0, 32'h3);   // lands on the terminal-count edge
    bus_read(3'd6, rd); check("blink_off_phase", rd & 32'h1, 32'h0);
    tick(1);
    check("blink_off_hex1", {24'd0, hex1}, 32'h86);
    tick(BDIV * 2);
    check("blink_off_hold", {24'd0, hex1}, 32'h86);

    // Raw mode then disable
    bus_write(3'd0, 32'h1);
    bus_write(3'd4, 32'h1234_5678);
    bus_write(3'd5, 32'h0000_9ABC);
    tick(1);
    check("raw_hex0", {24'd0, hex0}, 32'h78);
    check("raw_hex3", {24'd0, hex3}, 32'h12);
    check("raw_hex5", {24'd0, hex5}, 32'h9A);
    bus_write(3'd0, 32'h0);
    tick(1);
    for (int i = 0; i < 6; i++) check($sformatf("off_hex%0d", i), {24'd0, hx[i]}, 32'hFF);

    // Scroll
    bus_write(3'd2, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd1, 32'h0054_3210);
    bus_write(3'd0, 32'hB);
`ifdef HEX_DISPLAY_SCROLL_EN
    n = 0;
    while (m_pos() != 1 && n < 40) begin tick(1); n++; end
    check("wait_pos1", (n < 40) ? 1 : 0, 1);
    bus_read(3'd6, rd); check("status_pos1", rd, 32'h2);
    tick(1);
    check("scroll_hex0", {24'd0, hex0}, 32'hF9);
    tick(SDIV * 6);
    bus_write(3'd0, 32'h3);
    bus_read(3'd6, rd); check("scroll_off_status", rd, 32'h0);
`else
    tick(SDIV * 2);
    bus_read(3'd6, rd); check("noscroll_status", rd, 32'h0);
    bus_read(3'd0, rd); check("noscroll_ctrl", rd, 32'h3);
    check("noscroll_hex0", {24'd0, hex0}, 32'hC0);
`endif

    // Asynchronous reset mid-operation
    bus_write(3'd3, 32'h3F);
    bus_write(3'd0, 32'hF);
    n = 0;
`ifdef HEX_DISPLAY_SCROLL_EN
    while (!(m_pos() == 3 && m_phase() == 1) && n < 200) begin tick(1); n++; end
`else
    while (m_phase() != 1 && n < 200) begin tick(1); n++; end
`endif
    check("wait_rst_point", (n < 200) ? 1 : 0, 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 6; i++) check($sformatf("arst_hex%0d", i), {24'd0, hx[i]}, 32'hFF);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    bus_read(3'd6, rd); check("arst_status", rd, 32'h0);
    bus_read(3'd0, rd); check("arst_ctrl", rd, 32'h3);

    // Randomized register traffic
    for (int it = 0; it < 300; it++) begin
      int act;
      logic [2:0] a;
      logic [31:0] d;
      act = $urandom_range(0, 9);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (act < 5) begin
        if (a == 3'd0) begin
          if ($urandom_range(0, 2) != 0) a = 3'd1;
          else d[0] = ($urandom_range(0, 3) != 0);
        end
        bus_write(a, d);
      end else if (act < 8) begin
        bus_read(a, rd);
        check("rd_rand", rd, m_read(a));
        tick(1);
      end else begin
        tick($urandom_range(1, 12));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Avalon-MM slave controller that drives six 7-segment digits (HEX0..HEX5) on the MAX10 board from the Nios II. It replaces per-digit raw PIO writes with one register set holding a 24-bit hex value, per-digit decimal points, per-digit blink and an optional rotating scroll. The block sits on the Nios II data master next to the LED/PIO slaves and owns the HEX pins outright.

## Interface
- NUM_DIGITS, 6, digit count; fixed at 6, other values unsupported.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be ≥2.
- SCROLL_DIV, 12500000, clk cycles per scroll step; must be ≥2.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe; readdata valid regardless.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states.
- hex0..hex5  out  8 each  active-low segments, bit0=a … bit6=g, bit7=DP.

## Operation
- Registers; write when chipselect && !write_n:
  - 0 CTRL: [0] enable, [1] decode (1 = hex decode of VALUE, 0 = RAW), [2] blink_en, [3] scroll_en. Reset 0x3.
  - 1 VALUE: [23:0], nibble i = digit i. Reset 0.
  - 2 DP: [5:0], 1 = DP lit on physical digit i. Reset 0.
  - 3 BLINK_MASK: [5:0], physical digits that blink. Reset 0.
  - 4 RAW_LO: bytes = raw segments, digits 0..3. Reset 0xFFFFFFFF.
  - 5 RAW_HI: [15:0] = digits 4..5. Reset 0xFFFF.
  - 6 STATUS, read-only: [0] blink phase, [3:1] scroll pos. Writes ignored.
  - 7 reserved: reads 0, writes ignored.
- Unused register bits read 0.
- Decode, active-low: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Output pipeline per physical digit i:
  - Source digit s = (i + pos) mod 6.
  - Pattern = decode(VALUE nibble s) or RAW byte s, selected by CTRL[1].
  - Bit7 cleared if DP[i].
  - Forced to 0xFF if blink_en && BLINK_MASK[i] && phase=1.
  - Forced to 0xFF if enable=0.
- Blink counter (0..BLINK_DIV-1):
  - Runs only when enable && blink_en.
  - At BLINK_DIV-1 it wraps to 0 and phase toggles.
  - When not running, counter=0 and phase=0.
- Scroll FSM, states IDLE and RUN:
  - IDLE→RUN when enable && scroll_en.
  - RUN→IDLE when either bit drops; IDLE forces pos=0 and the scroll counter to 0.
  - In RUN the counter counts 0..SCROLL_DIV-1; at the terminal count pos increments and wraps 5→0.
- Simultaneous events:
  - A CTRL write that disables blink or scroll on the same edge as a terminal count wins: no toggle or increment, and the counter clears.
  - Writing VALUE mid-scroll does not change pos.

## Timing
- Register write is captured on edge N; hex outputs reflect it after edge N+1 (registered outputs, latency 1).
- readdata is combinational from the registers, so a read on the cycle after edge N returns the new value.
- On reset: all hex outputs 0xFF, phase 0, pos 0, FSM IDLE, counters 0.
- First edge after reset release: outputs 0xC0 (shows "000000").
- Blink phase toggles every BLINK_DIV cycles while running; a blinked digit is blank for BLINK_DIV cycles out of every 2·BLINK_DIV.
- pos advances every SCROLL_DIV cycles in RUN; the output changes one cycle after the pos change.
- Reset asserted mid-operation clears everything asynchronously; outputs go 0xFF immediately.

## Configuration
- HEX_DISPLAY_SCROLL_EN defined: scroll FSM, counter and pos logic are present as described.
- Undefined: no scroll hardware; pos is tied to 0, CTRL[3] is writable but reads 0 and has no effect, STATUS[3:1] reads 0.

## Test plan
- Reset, then release; no writes → hex0..hex5 = 0xFF during reset, 0xC0 one cycle after release; CTRL reads 0x3, RAW_LO reads 0xFFFFFFFF.
- Write VALUE=0x00A5E9, DP=0x01 → two cycles later hex0=0x10, hex1=0x86, hex2=0x92, hex3=0x88, hex4=hex5=0xC0.
- BLINK_DIV=4, CTRL=0x7, BLINK_MASK=0x02 → hex1 toggles between its pattern and 0xFF every 4 cycles. Clearing CTRL[2] on a terminal-count edge → phase stays 0 and the digit stays lit.
- CTRL=0x1, RAW_LO=0x12345678, RAW_HI=0x9ABC → hex0=0x78, hex3=0x12, hex5=0x9A; then CTRL=0x0 → all 0xFF next cycle.
- With HEX_DISPLAY_SCROLL_EN, SCROLL_DIV=8, VALUE=0x543210, CTRL=0xB → pos steps 0..5 and wraps to 0 every 8 cycles; at pos=1, hex0 shows decode(1)=0xF9. Clearing CTRL[3] → pos=0 next edge, STATUS[3:1]=0.
- Assert reset_n low mid-scroll at pos=3 with phase=1 → outputs 0xFF asynchronously, pos=0 and phase=0 after release.
